// File: rtl/tri_edge_sequencer_pkg.sv
// Shared definitions for the triangle edge sequencer: FSM encoding and record layout.
package tri_edge_sequencer_pkg;

    localparam int unsigned STATE_W   = 3;
    localparam int unsigned EDGE_W    = 2;
    localparam int unsigned REC_WORDS = 9;

    localparam logic [STATE_W-1:0] ST_IDLE    = 3'd0;
    localparam logic [STATE_W-1:0] ST_WAIT_LD = 3'd1;
    localparam logic [STATE_W-1:0] ST_FETCH   = 3'd2;
    localparam logic [STATE_W-1:0] ST_CAPTURE = 3'd3;
    localparam logic [STATE_W-1:0] ST_EMIT    = 3'd4;
    localparam logic [STATE_W-1:0] ST_NEXT    = 3'd5;
    localparam logic [STATE_W-1:0] ST_FIN     = 3'd6;

    // Word offsets inside one triangle record; words 7 and 8 are unused.
    localparam int unsigned W_X0    = 0;
    localparam int unsigned W_Y0    = 1;
    localparam int unsigned W_X1    = 2;
    localparam int unsigned W_Y1    = 3;
    localparam int unsigned W_X2    = 4;
    localparam int unsigned W_Y2    = 5;
    localparam int unsigned W_COLOR = 6;

    // Skip flag lives in the MSB of the colour word.
    function automatic int unsigned skip_bit(input int unsigned data_width);
        return data_width - 1;
    endfunction

endpackage

// File: rtl/tri_edge_mux.sv
// Selects the endpoint pair of one triangle edge: 0 = v0->v1, 1 = v1->v2, 2 = v2->v0.
module tri_edge_mux
    import tri_edge_sequencer_pkg::*;
#(
    parameter int unsigned COORD_W = 16
) (
    input  logic [EDGE_W-1:0]  edge_idx,
    input  logic [COORD_W-1:0] vx0,
    input  logic [COORD_W-1:0] vy0,
    input  logic [COORD_W-1:0] vx1,
    input  logic [COORD_W-1:0] vy1,
    input  logic [COORD_W-1:0] vx2,
    input  logic [COORD_W-1:0] vy2,
    output logic [COORD_W-1:0] x0_c,
    output logic [COORD_W-1:0] y0_c,
    output logic [COORD_W-1:0] x1_c,
    output logic [COORD_W-1:0] y1_c
);

    always_comb begin
        x0_c = vx0;
        y0_c = vy0;
        x1_c = vx1;
        y1_c = vy1;
        case (edge_idx)
            2'd1: begin
                x0_c = vx1;
                y0_c = vy1;
                x1_c = vx2;
                y1_c = vy2;
            end
            2'd2: begin
                x0_c = vx2;
                y0_c = vy2;
                x1_c = vx0;
                y1_c = vy0;
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/tri_edge_sequencer.sv
// Walks the loader's triangle table in RAM and streams each triangle's three edges
// to the line rasterizer over a valid/ready handshake.
module tri_edge_sequencer
    import tri_edge_sequencer_pkg::*;
#(
    parameter int unsigned addr_width = 8,
    parameter int unsigned data_width = 32,
    parameter int unsigned COORD_W    = 16,
    parameter int unsigned NUM_TRI    = 2,
    parameter int unsigned BASE_ADDR  = 0,
    parameter int unsigned REC_STRIDE = 9
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start,
    input  logic                  loader_finish,
    output logic [addr_width-1:0] ram_read_addr,
    input  logic [data_width-1:0] ram_read_data1,
    input  logic [data_width-1:0] ram_read_data2,
    input  logic [data_width-1:0] ram_read_data3,
    input  logic [data_width-1:0] ram_read_data4,
    input  logic [data_width-1:0] ram_read_data5,
    input  logic [data_width-1:0] ram_read_data6,
    input  logic [data_width-1:0] ram_read_data7,
    input  logic [data_width-1:0] ram_read_data8,
    input  logic [data_width-1:0] ram_read_data9,
    output logic                  line_valid,
    input  logic                  line_ready,
    output logic [COORD_W-1:0]    line_x0,
    output logic [COORD_W-1:0]    line_y0,
    output logic [COORD_W-1:0]    line_x1,
    output logic [COORD_W-1:0]    line_y1,
    output logic [data_width-1:0] line_color,
    output logic                  busy,
    output logic                  done
);

    localparam int unsigned TRI_W    = (NUM_TRI > 1) ? $clog2(NUM_TRI) : 1;
    localparam int unsigned SKIP_BIT = skip_bit(data_width);

    if (NUM_TRI == 0) begin : g_bad_num_tri
        $error("tri_edge_sequencer: NUM_TRI must be at least 1");
    end

    logic [STATE_W-1:0]    state_q, state_nxt;
    logic [TRI_W-1:0]      tri_q, tri_nxt, tri_inc;
    logic [EDGE_W-1:0]     edge_q, edge_nxt;
    logic [addr_width-1:0] addr_nxt;
    logic                  valid_nxt, busy_nxt, done_nxt;
    logic [data_width-1:0] color_nxt;
    logic [COORD_W-1:0]    vx0_q, vy0_q, vx1_q, vy1_q, vx2_q, vy2_q;
    logic [COORD_W-1:0]    vx0_nxt, vy0_nxt, vx1_nxt, vy1_nxt, vx2_nxt, vy2_nxt;
    logic [COORD_W-1:0]    mx0_c, my0_c, mx1_c, my1_c;
    logic                  unused_bits;

    // Record words 7..8 and the coordinate MSBs are not consumed.
    assign unused_bits = ^{ram_read_data1, ram_read_data2, ram_read_data3, ram_read_data4,
                           ram_read_data5, ram_read_data6, ram_read_data8, ram_read_data9};

    function automatic logic [addr_width-1:0] rec_addr(input logic [TRI_W-1:0] idx);
        return addr_width'(BASE_ADDR + REC_STRIDE * 32'(idx));
    endfunction

    assign tri_inc = tri_q + TRI_W'(1);

    // Next-state and next-register logic.
    always_comb begin
        state_nxt = state_q;
        tri_nxt   = tri_q;
        edge_nxt  = edge_q;
        addr_nxt  = ram_read_addr;
        valid_nxt = line_valid;
        color_nxt = line_color;
        done_nxt  = 1'b0;
        vx0_nxt   = vx0_q;
        vy0_nxt   = vy0_q;
        vx1_nxt   = vx1_q;
        vy1_nxt   = vy1_q;
        vx2_nxt   = vx2_q;
        vy2_nxt   = vy2_q;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    state_nxt = ST_WAIT_LD;
                    tri_nxt   = '0;
                end
            end
            ST_WAIT_LD: begin
                if (loader_finish) begin
                    state_nxt = ST_FETCH;
                    addr_nxt  = rec_addr(tri_q);
                end
            end
            ST_FETCH: state_nxt = ST_CAPTURE;
            ST_CAPTURE: begin
                vx0_nxt   = ram_read_data1[COORD_W-1:0];
                vy0_nxt   = ram_read_data2[COORD_W-1:0];
                vx1_nxt   = ram_read_data3[COORD_W-1:0];
                vy1_nxt   = ram_read_data4[COORD_W-1:0];
                vx2_nxt   = ram_read_data5[COORD_W-1:0];
                vy2_nxt   = ram_read_data6[COORD_W-1:0];
                color_nxt = ram_read_data7;
                edge_nxt  = '0;
                if (ram_read_data7[SKIP_BIT]) begin
                    state_nxt = ST_NEXT;
                end else begin
                    state_nxt = ST_EMIT;
                    valid_nxt = 1'b1;
                end
            end
            ST_EMIT: begin
                // One bubble cycle after each handshake while the next edge is loaded.
                if (!line_valid) begin
                    valid_nxt = 1'b1;
                end else if (line_ready) begin
                    valid_nxt = 1'b0;
                    if (edge_q == EDGE_W'(2)) begin
                        state_nxt = ST_NEXT;
                    end else begin
                        edge_nxt = edge_q + EDGE_W'(1);
                    end
                end
            end
            ST_NEXT: begin
                if (tri_q == TRI_W'(NUM_TRI - 1)) begin
                    state_nxt = ST_FIN;
                    done_nxt  = 1'b1;
                end else begin
                    state_nxt = ST_FETCH;
                    tri_nxt   = tri_inc;
                    addr_nxt  = rec_addr(tri_inc);
                end
            end
            ST_FIN:  state_nxt = ST_IDLE;
            default: state_nxt = ST_IDLE;
        endcase
        busy_nxt = (state_nxt != ST_IDLE);
    end

    tri_edge_mux #(
        .COORD_W (COORD_W)
    ) u_edge_mux (
        .edge_idx (edge_nxt),
        .vx0      (vx0_nxt),
        .vy0      (vy0_nxt),
        .vx1      (vx1_nxt),
        .vy1      (vy1_nxt),
        .vx2      (vx2_nxt),
        .vy2      (vy2_nxt),
        .x0_c     (mx0_c),
        .y0_c     (my0_c),
        .x1_c     (mx1_c),
        .y1_c     (my1_c)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q       <= ST_IDLE;
            tri_q         <= '0;
            edge_q        <= '0;
            ram_read_addr <= '0;
            line_valid    <= 1'b0;
            line_color    <= '0;
            busy          <= 1'b0;
            done          <= 1'b0;
            vx0_q         <= '0;
            vy0_q         <= '0;
            vx1_q         <= '0;
            vy1_q         <= '0;
            vx2_q         <= '0;
            vy2_q         <= '0;
            line_x0       <= '0;
            line_y0       <= '0;
            line_x1       <= '0;
            line_y1       <= '0;
        end else begin
            state_q       <= state_nxt;
            tri_q         <= tri_nxt;
            edge_q        <= edge_nxt;
            ram_read_addr <= addr_nxt;
            line_valid    <= valid_nxt;
            line_color    <= color_nxt;
            busy          <= busy_nxt;
            done          <= done_nxt;
            vx0_q         <= vx0_nxt;
            vy0_q         <= vy0_nxt;
            vx1_q         <= vx1_nxt;
            vy1_q         <= vy1_nxt;
            vx2_q         <= vx2_nxt;
            vy2_q         <= vy2_nxt;
            line_x0       <= mx0_c;
            line_y0       <= my0_c;
            line_x1       <= mx1_c;
            line_y1       <= my1_c;
        end
    end

endmodule

// File: tb/tb_tri_edge_sequencer.sv
// Directed bench for tri_edge_sequencer with a registered-read RAM model.
module tb_tri_edge_sequencer;

    localparam int unsigned AW = 8;
    localparam int unsigned DW = 32;
    localparam int unsigned CW = 16;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          start;
    logic          loader_finish;
    logic          line_ready;
    logic [AW-1:0] ram_read_addr;
    logic [DW-1:0] rd [9];
    logic          line_valid;
    logic [CW-1:0] line_x0, line_y0, line_x1, line_y1;
    logic [DW-1:0] line_color;
    logic          busy;
    logic          done;

    logic [DW-1:0] mem [256];

    int n_vec = 0;
    int n_err = 0;
    int done_cnt = 0;
    int done_base;
    int acc_base;

    logic [95:0]   acc_q[$];
    logic [AW-1:0] acc_addr_q[$];
    logic [95:0]   exp_q[$];
    logic [AW-1:0] exp_addr_q[$];

    always #5 clk = ~clk;

    always @(posedge clk) begin
        for (int k = 0; k < 9; k++) rd[k] <= mem[AW'(ram_read_addr + AW'(k))];
    end

    tri_edge_sequencer #(
        .addr_width (AW),
        .data_width (DW),
        .COORD_W    (CW),
        .NUM_TRI    (2),
        .BASE_ADDR  (0),
        .REC_STRIDE (9)
    ) dut (
        .clk            (clk),
        .reset          (rst_n),
        .start          (start),
        .loader_finish  (loader_finish),
        .ram_read_addr  (ram_read_addr),
        .ram_read_data1 (rd[0]),
        .ram_read_data2 (rd[1]),
        .ram_read_data3 (rd[2]),
        .ram_read_data4 (rd[3]),
        .ram_read_data5 (rd[4]),
        .ram_read_data6 (rd[5]),
        .ram_read_data7 (rd[6]),
        .ram_read_data8 (rd[7]),
        .ram_read_data9 (rd[8]),
        .line_valid     (line_valid),
        .line_ready     (line_ready),
        .line_x0        (line_x0),
        .line_y0        (line_y0),
        .line_x1        (line_x1),
        .line_y1        (line_y1),
        .line_color     (line_color),
        .busy           (busy),
        .done           (done)
    );

    // Record every accepted edge with the address in effect, and count done pulses.
    always @(negedge clk) begin
        if (line_valid && line_ready) begin
            acc_q.push_back({line_x0, line_y0, line_x1, line_y1, line_color});
            acc_addr_q.push_back(ram_read_addr);
        end
        if (done) done_cnt++;
    end

    task automatic check_vec(input string tag, input logic [95:0] got, input logic [95:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic push_edge(input logic [15:0] x0, input logic [15:0] y0, input logic [15:0] x1,
                             input logic [15:0] y1, input logic [31:0] col, input logic [7:0] addr);
        exp_q.push_back({x0, y0, x1, y1, col});
        exp_addr_q.push_back(addr);
    endtask

    task automatic push_rec0();
        push_edge(10, 20, 30, 40, 32'h00FF_0000, 0);
        push_edge(30, 40, 50, 5, 32'h00FF_0000, 0);
        push_edge(50, 5, 10, 20, 32'h00FF_0000, 0);
    endtask

    task automatic push_rec1();
        push_edge(0, 0, 7, 7, 32'h1, 9);
        push_edge(7, 7, 0, 7, 32'h1, 9);
        push_edge(0, 7, 0, 0, 32'h1, 9);
    endtask

    task automatic begin_test();
        acc_base  = acc_q.size();
        done_base = done_cnt;
        exp_q.delete();
        exp_addr_q.delete();
    endtask

    task automatic pulse_start();
        @(posedge clk); #1 start = 1'b1;
        @(posedge clk); #1 start = 1'b0;
    endtask

    task automatic wait_done();
        for (int i = 0; i < 400; i++) begin
            @(negedge clk);
            if (done_cnt - done_base >= 1 && !busy) break;
        end
        repeat (3) @(negedge clk);
    endtask

    task automatic wait_valid(input string tag);
        for (int i = 0; i < 40; i++) begin
            if (line_valid) break;
            @(negedge clk);
        end
        check_vec(tag, 96'(line_valid), 96'(1));
    endtask

    task automatic wait_accepts(input int n);
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (acc_q.size() - acc_base >= n) break;
        end
    endtask

    task automatic expect_pass(input string tag);
        int got_n;
        int m;
        got_n = acc_q.size() - acc_base;
        check_vec({tag, "_edges"}, 96'(got_n), 96'(exp_q.size()));
        m = (got_n < exp_q.size()) ? got_n : exp_q.size();
        for (int i = 0; i < m; i++) begin
            check_vec($sformatf("%s_edge%0d", tag, i), acc_q[acc_base + i], exp_q[i]);
            check_vec($sformatf("%s_addr%0d", tag, i), 96'(acc_addr_q[acc_base + i]), 96'(exp_addr_q[i]));
        end
        check_vec({tag, "_done"}, 96'(done_cnt - done_base), 96'(1));
    endtask

    task automatic do_reset();
        @(posedge clk); #1 rst_n = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        #400000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        rst_n         = 1'b0;
        start         = 1'b0;
        loader_finish = 1'b1;
        line_ready    = 1'b1;
        for (int i = 0; i < 256; i++) mem[i] = 32'h0;
        mem[0] = 10; mem[1] = 20; mem[2] = 30; mem[3] = 40; mem[4] = 50; mem[5] = 5;
        mem[6] = 32'h00FF_0000; mem[7] = 32'hDEAD_BEEF; mem[8] = 32'hFFFF_FFFF;
        mem[9] = 0; mem[10] = 0; mem[11] = 7; mem[12] = 7; mem[13] = 0; mem[14] = 7;
        mem[15] = 32'h1; mem[16] = 32'h1234_5678; mem[17] = 32'hCAFE_F00D;

        // Reset state
        repeat (2) @(negedge clk);
        check_vec("rst_valid", 96'(line_valid), 96'(0));
        check_vec("rst_busy", 96'(busy), 96'(0));
        check_vec("rst_done", 96'(done), 96'(0));
        check_vec("rst_addr", 96'(ram_read_addr), 96'(0));
        check_vec("rst_coord", {line_x0, line_y0, line_x1, line_y1}, 96'(0));
        check_vec("rst_color", 96'(line_color), 96'(0));
        rst_n = 1'b1;

        // Single pass with latency checks
        begin_test(); push_rec0(); push_rec1();
        pulse_start();
        @(negedge clk);
        check_vec("lat_c1_busy", 96'(busy), 96'(1));
        check_vec("lat_c1_valid", 96'(line_valid), 96'(0));
        @(negedge clk);
        check_vec("lat_c2_addr", 96'(ram_read_addr), 96'(0));
        @(negedge clk);
        check_vec("lat_c3_valid", 96'(line_valid), 96'(0));
        @(negedge clk);
        check_vec("lat_c4_valid", 96'(line_valid), 96'(1));
        check_vec("lat_c4_edge", {line_x0, line_y0, line_x1, line_y1}, {16'd10, 16'd20, 16'd30, 16'd40});
        wait_done();
        expect_pass("pass1");
        check_vec("pass1_addr_end", 96'(ram_read_addr), 96'(9));

        // Backpressure on edge 1
        begin_test(); push_rec0(); push_rec1();
        line_ready = 1'b0;
        pulse_start();
        wait_valid("bp_v0");
        @(posedge clk); #1 line_ready = 1'b1;
        @(negedge clk);
        @(posedge clk); #1 line_ready = 1'b0;
        @(negedge clk);
        wait_valid("bp_v1");
        for (int i = 0; i < 5; i++) begin
            check_vec($sformatf("bp_hold_valid%0d", i), 96'(line_valid), 96'(1));
            check_vec($sformatf("bp_hold_edge%0d", i), {line_x0, line_y0, line_x1, line_y1},
                      {16'd30, 16'd40, 16'd50, 16'd5});
            if (i < 4) @(negedge clk);
        end
        @(posedge clk); #1 line_ready = 1'b1;
        wait_done();
        expect_pass("bp");

        // Wait for loader
        do_reset();
        begin_test(); push_rec0(); push_rec1();
        loader_finish = 1'b0;
        pulse_start();
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            check_vec($sformatf("wl_addr%0d", i), 96'(ram_read_addr), 96'(0));
            check_vec($sformatf("wl_valid%0d", i), 96'(line_valid), 96'(0));
            check_vec($sformatf("wl_busy%0d", i), 96'(busy), 96'(1));
        end
        @(posedge clk); #1 loader_finish = 1'b1;
        repeat (3) @(negedge clk);
        check_vec("wl_l2_valid", 96'(line_valid), 96'(0));
        @(negedge clk);
        check_vec("wl_l3_valid", 96'(line_valid), 96'(1));
        @(posedge clk); #1 loader_finish = 1'b0;
        wait_done();
        expect_pass("wl");
        loader_finish = 1'b1;

        // Skip flag on record 0
        mem[6] = 32'h8000_0000;
        begin_test(); push_rec1();
        pulse_start();
        wait_done();
        expect_pass("skip");
        mem[6] = 32'h00FF_0000;

        // Asynchronous reset while edge 2 of record 0 is presented
        begin_test();
        line_ready = 1'b1;
        pulse_start();
        wait_accepts(2);
        @(posedge clk); #1 line_ready = 1'b0;
        @(negedge clk);
        wait_valid("ar_v2");
        check_vec("ar_edge2", {line_x0, line_y0, line_x1, line_y1}, {16'd50, 16'd5, 16'd10, 16'd20});
        #2 rst_n = 1'b0;
        #1;
        check_vec("ar_valid", 96'(line_valid), 96'(0));
        check_vec("ar_busy", 96'(busy), 96'(0));
        check_vec("ar_done", 96'(done), 96'(0));
        repeat (2) @(posedge clk);
        @(negedge clk);
        check_vec("ar_addr", 96'(ram_read_addr), 96'(0));
        check_vec("ar_coord", {line_x0, line_y0, line_x1, line_y1}, 96'(0));
        rst_n = 1'b1;
        line_ready = 1'b1;
        begin_test(); push_rec0(); push_rec1();
        pulse_start();
        wait_done();
        expect_pass("replay");

        // start while busy is ignored
        begin_test(); push_rec0(); push_rec1();
        pulse_start();
        wait_accepts(1);
        @(posedge clk); #1 start = 1'b1;
        @(posedge clk); #1 start = 1'b0;
        wait_done();
        repeat (10) @(negedge clk);
        expect_pass("sb");
        check_vec("sb_idle", 96'(busy), 96'(0));

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
